vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Schedules the single-port framebuffer RAM between VGA scan-out and two pixel writers: a GPU core on writer 0 and the host loader on writer 1.
- Sits between vga_sync (pos_x, pos_y, blank_n) and the framebuffer RAM.
- Scan-out reads have strict priority. The two writers share the remaining slots round-robin.
- Tracks frame phase and emits frame/vblank pulses that the GPU uses for tear-free updates.

Parameters:
- FB_W, 91, framebuffer width in pixels (640/7).
- FB_H, 68, framebuffer height in pixels (480/7).
- ADDR_W, 13, RAM address width (FB_W*FB_H = 6188).
- DATA_W, 8, pixel width (RGB332).
- BG_COLOR, 0, pixel driven outside the visible framebuffer area.
- WR_VBL_ONLY, 0, when 1, writes are granted only in S_VBL.

Ports:
- clk0  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clk_div2  in  1  pixel strobe, high every other clk0 cycle
- pos_x  in  10  pixel x from vga_sync
- pos_y  in  10  pixel y from vga_sync; wraps to a large value during blanking
- blank_n  in  1  active video from vga_sync
- wr0_valid  in  1  writer 0 request
- wr0_addr  in  ADDR_W  writer 0 address
- wr0_data  in  DATA_W  writer 0 data
- wr0_ready  out  1  writer 0 accept
- wr1_valid, wr1_addr, wr1_data, wr1_ready: same as writer 0, for writer 1
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- pix_data  out  DATA_W  pixel to DAC
- frame_start  out  1  1-cycle pulse on S_VBL->S_SCAN
- vblank_start  out  1  1-cycle pulse on S_SCAN->S_VBL
- in_vblank  out  1  high in S_VBL

Behaviour:
- Single clock domain, clk0. All state updates only when rst=0. Reset is synchronous.
- Reset values:
  - pix_data=BG_COLOR; mem_we=0; mem_addr=0; mem_wdata=0; wr*_ready=0.
  - frame_start=0; vblank_start=0; in_vblank=1.
  - state=S_VBL; last_grant=1, so writer 0 wins first; cache_vld=0.
- Visibility: vis = blank_n && pos_x<FB_W && pos_y<FB_H, combinational. rd_addr = pos_y*FB_W + pos_x, truncated to ADDR_W.
- Frame FSM, evaluated every clk0:
  - S_VBL -> S_SCAN when pos_y<FB_H; frame_start=1 for one cycle; cache_vld cleared.
  - S_SCAN -> S_VBL when pos_y>=FB_H; vblank_start=1 for one cycle.
  - Pulses are registered and never overlap.
- Display slot, a cycle with clk_div2=1:
  - need_rd = vis && !(cache_vld && cache_addr==rd_addr).
  - If need_rd: mem_addr=rd_addr, mem_we=0, both readies=0, cache_addr<=rd_addr.
  - Next cycle: pix_data<=mem_rdata, cache_vld<=1. Pixel latency is 2 clk0 cycles from the slot.
  - If !need_rd: the slot is free for writers.
- pix_data rules:
  - Holds its value while vis stays high and cache hits.
  - Set to BG_COLOR on the cycle after a display slot with vis=0.
- Writer grant:
  - A cycle is eligible when the port is not used by a display read and (!WR_VBL_ONLY || state==S_VBL).
  - Only wr*_valid gates readiness; never combinationally from wr*_ready.
  - Both valid: grant the writer != last_grant. Otherwise grant the single valid writer.
  - Grant: wrN_ready=1 combinationally in that cycle, mem_we=1, mem_addr/mem_wdata from writer N, last_grant<=N.
  - Transfer occurs on valid&&ready.
  - No grant (idle): mem_we=0, mem_addr holds.
- Coherency: a write with wr_addr==cache_addr clears cache_vld, so the next display slot re-reads. A simultaneous display read never coincides with a write (one port, display priority).
- mem_addr, mem_we and wr*_ready are a combinational arbitration decode. pix_data and all flags are registered.
- rst asserted mid-frame or mid-transfer: all outputs return to reset values next cycle. No in-flight write is retried.

Decomposition:
- Package vga_fb_pkg:
  - FB_W, FB_H, ADDR_W, DATA_W defaults.
  - State enum {S_VBL, S_SCAN}.
  - Grant index type.
- Sub-module rr_arb2: 2-way round-robin with last_grant register, inputs req[1:0] and en, outputs gnt[1:0].

Test Plan:
- Reset, then release with rst=1 for 3 cycles -> in_vblank=1, pix_data=0, readies=0, mem_we=0.
- Only wr0_valid, addr=5, data=0xAA, during S_VBL -> wr0_ready=1 same cycle; mem_we=1, mem_addr=5, mem_wdata=0xAA.
- wr0_valid and wr1_valid held 4 eligible cycles -> grants alternate 0,1,0,1.
- Scan pixel (pos_x=3, pos_y=2), mem_rdata=0x5C -> read at mem_addr=185 in clk_div2 slot; pix_data=0x5C two cycles later; further slots at the same address issue no read, and writers are granted.
- Write addr=185 while cached -> next display slot re-reads 185; pix_data updates to the new data.
- WR_VBL_ONLY=1, wr1_valid held through S_SCAN -> wr1_ready=0 until the vblank_start pulse, granted in the first free S_VBL cycle.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types and default geometry for the VGA framebuffer arbiter.
// The framebuffer is the 640x480 raster downscaled by 7 in each axis.
package vga_fb_pkg;

    localparam int FB_W   = 91;
    localparam int FB_H   = 68;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    typedef enum logic {
        S_VBL,
        S_SCAN
    } state_e;

    typedef logic gnt_idx_t;

endpackage

// File: rtl/vga_fb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// With both requesting, the one that did not win last time is granted.
import vga_fb_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    gnt_idx_t last_q;
    gnt_idx_t last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    // Starts at 1 so writer 0 wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer scheduler: scan-out reads first, then the
// two pixel writers round-robin; also tracks the frame/vblank phase.
import vga_fb_pkg::*;

module vga_fb_arbiter #(
    parameter int                FB_W        = vga_fb_pkg::FB_W,
    parameter int                FB_H        = vga_fb_pkg::FB_H,
    parameter int                ADDR_W      = vga_fb_pkg::ADDR_W,
    parameter int                DATA_W      = vga_fb_pkg::DATA_W,
    parameter logic [DATA_W-1:0] BG_COLOR    = '0,
    parameter bit                WR_VBL_ONLY = 1'b0
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic              clk_div2,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              blank_n,
    input  logic              wr0_valid,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              frame_start,
    output logic              vblank_start,
    output logic              in_vblank
);

    localparam logic [9:0]  FB_W10 = 10'(FB_W);
    localparam logic [9:0]  FB_H10 = 10'(FB_H);
    localparam logic [19:0] FB_W20 = 20'(FB_W);

    state_e              state_q, state_d;
    logic                frame_start_q, frame_start_d;
    logic                vblank_start_q, vblank_start_d;
    logic                cache_vld_q, cache_vld_d;
    logic [ADDR_W-1:0]   cache_addr_q;
    logic                rd_pend_q;
    logic [DATA_W-1:0]   pix_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                y_in;
    logic                vis;
    logic [19:0]         rd_full;
    logic [ADDR_W-1:0]   rd_addr;
    logic                slot;
    logic                hit;
    logic                need_rd;
    logic                wr_en;
    logic [1:0]          gnt;
    logic                wr_hit;

    assign y_in    = pos_y < FB_H10;
    assign vis     = blank_n && (pos_x < FB_W10) && y_in;
    assign rd_full = 20'(pos_y) * FB_W20 + 20'(pos_x);
    assign rd_addr = rd_full[ADDR_W-1:0];

    assign slot    = clk_div2 && !rst;
    assign hit     = cache_vld_q && (cache_addr_q == rd_addr);
    assign need_rd = slot && vis && !hit;
    assign wr_en   = !rst && !need_rd
                  && (!WR_VBL_ONLY || state_q == S_VBL);

    rr_arb2 u_arb (
        .clk (clk0),
        .rst (rst),
        .req ({wr1_valid, wr0_valid}),
        .en  (wr_en),
        .gnt (gnt)
    );

    always_comb begin
        state_d        = state_q;
        frame_start_d  = 1'b0;
        vblank_start_d = 1'b0;
        unique case (state_q)
            S_VBL: begin
                if (y_in) begin
                    state_d       = S_SCAN;
                    frame_start_d = 1'b1;
                end
            end
            S_SCAN: begin
                if (!y_in) begin
                    state_d        = S_VBL;
                    vblank_start_d = 1'b1;
                end
            end
            default: state_d = S_VBL;
        endcase
    end

    always_comb begin
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        mem_we    = 1'b0;
        wr0_ready = gnt[0];
        wr1_ready = gnt[1];
        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (need_rd) begin
            mem_addr = rd_addr;
        end else if (gnt[0]) begin
            mem_we    = 1'b1;
            mem_addr  = wr0_addr;
            mem_wdata = wr0_data;
        end else if (gnt[1]) begin
            mem_we    = 1'b1;
            mem_addr  = wr1_addr;
            mem_wdata = wr1_data;
        end
    end

    assign wr_hit = mem_we && (mem_addr == cache_addr_q);

    // A write landing on the cached pixel (even one whose read is still
    // in flight) forces the next display slot to fetch again.
    always_comb begin
        cache_vld_d = cache_vld_q;
        if (rd_pend_q) begin
            cache_vld_d = 1'b1;
        end
        if (wr_hit || frame_start_d) begin
            cache_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q        <= S_VBL;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            cache_vld_q    <= 1'b0;
            cache_addr_q   <= '0;
            rd_pend_q      <= 1'b0;
            pix_q          <= BG_COLOR;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
            cache_vld_q    <= cache_vld_d;
            rd_pend_q      <= need_rd;
            mem_addr_q     <= mem_addr;
            mem_wdata_q    <= mem_wdata;
            if (need_rd) begin
                cache_addr_q <= rd_addr;
            end
            if (rd_pend_q) begin
                pix_q <= mem_rdata;
            end else if (slot && !vis) begin
                pix_q <= BG_COLOR;
            end
        end
    end

    assign pix_data     = pix_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;
    assign in_vblank    = (state_q == S_VBL);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: reset, grants, scan-out read path,
// cache coherency, frame pulses and the vblank-only write mode.
module tb_vga_fb_arbiter;

    logic        clk0 = 1'b0;
    logic        rst;
    logic        clk_div2;
    logic [9:0]  pos_x, pos_y;
    logic        blank_n;
    logic        wr0_valid, wr1_valid;
    logic [12:0] wr0_addr, wr1_addr;
    logic [7:0]  wr0_data, wr1_data;
    logic [7:0]  mem_rdata;

    logic        wr0_ready, wr1_ready, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, pix_data;
    logic        frame_start, vblank_start, in_vblank;

    logic        v_wr0_ready, v_wr1_ready, v_mem_we;
    logic [12:0] v_mem_addr;
    logic [7:0]  v_mem_wdata, v_pix_data;
    logic        v_frame_start, v_vblank_start, v_in_vblank;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk0 = ~clk0;

    vga_fb_arbiter dut (
        .clk0(clk0), .rst(rst), .clk_div2(clk_div2),
        .pos_x(pos_x), .pos_y(pos_y), .blank_n(blank_n),
        .wr0_valid(wr0_valid), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_data(pix_data), .frame_start(frame_start),
        .vblank_start(vblank_start), .in_vblank(in_vblank)
    );

    vga_fb_arbiter #(.WR_VBL_ONLY(1'b1)) dut_v (
        .clk0(clk0), .rst(rst), .clk_div2(clk_div2),
        .pos_x(pos_x), .pos_y(pos_y), .blank_n(blank_n),
        .wr0_valid(wr0_valid), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data), .wr0_ready(v_wr0_ready),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data), .wr1_ready(v_wr1_ready),
        .mem_addr(v_mem_addr), .mem_we(v_mem_we),
        .mem_wdata(v_mem_wdata), .mem_rdata(mem_rdata),
        .pix_data(v_pix_data), .frame_start(v_frame_start),
        .vblank_start(v_vblank_start), .in_vblank(v_in_vblank)
    );

    task automatic nxt();
        @(negedge clk0);
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_div2 = 1'b0; pos_x = 10'd0; pos_y = 10'd500;
        blank_n = 1'b0; wr0_valid = 1'b1; wr1_valid = 1'b1;
        wr0_addr = 13'd0; wr0_data = 8'h00;
        wr1_addr = 13'd0; wr1_data = 8'h00; mem_rdata = 8'h00;
        repeat (3) nxt();
        #1;
        n_checks++; if (in_vblank !== 1'b1) begin n_fail++; $display("FAIL rst_in_vblank got %b exp 1", in_vblank); end
        n_checks++; if (pix_data !== 8'h00) begin n_fail++; $display("FAIL rst_pix got %h exp 00", pix_data); end
        n_checks++; if (wr0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr0_ready got %b exp 0", wr0_ready); end
        n_checks++; if (wr1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr1_ready got %b exp 0", wr1_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        n_checks++; if (mem_addr !== 13'd0) begin n_fail++; $display("FAIL rst_mem_addr got %0d exp 0", mem_addr); end
        n_checks++; if (frame_start !== 1'b0 || vblank_start !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got %b%b exp 00", frame_start, vblank_start); end
        nxt();
        rst = 1'b0; wr0_valid = 1'b0; wr1_valid = 1'b0;
    endtask

    task automatic test_single_write();
        nxt();
        wr0_valid = 1'b1; wr0_addr = 13'd5; wr0_data = 8'hAA;
        #1;
        n_checks++; if (wr0_ready !== 1'b1) begin n_fail++; $display("FAIL sw_wr0_ready got %b exp 1", wr0_ready); end
        n_checks++; if (wr1_ready !== 1'b0) begin n_fail++; $display("FAIL sw_wr1_ready got %b exp 0", wr1_ready); end
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_mem_we got %b exp 1", mem_we); end
        n_checks++; if (mem_addr !== 13'd5) begin n_fail++; $display("FAIL sw_mem_addr got %0d exp 5", mem_addr); end
        n_checks++; if (mem_wdata !== 8'hAA) begin n_fail++; $display("FAIL sw_mem_wdata got %h exp aa", mem_wdata); end
        nxt();
        wr0_valid = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_mem_we got %b exp 0", mem_we); end
        n_checks++; if (mem_addr !== 13'd5) begin n_fail++; $display("FAIL idle_addr_hold got %0d exp 5", mem_addr); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10;
        exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        nxt();
        wr1_valid = 1'b1; wr1_addr = 13'd7; wr1_data = 8'h33;
        #1;
        n_checks++; if (wr1_ready !== 1'b1 || mem_addr !== 13'd7 || mem_wdata !== 8'h33) begin n_fail++; $display("FAIL w1_only got rdy=%b addr=%0d data=%h exp 1 7 33", wr1_ready, mem_addr, mem_wdata); end
        wr0_addr = 13'd10; wr0_data = 8'h11;
        wr1_addr = 13'd20; wr1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            nxt();
            wr0_valid = 1'b1; wr1_valid = 1'b1;
            #1;
            n_checks++; if ({wr1_ready, wr0_ready} !== exp_g[i]) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, {wr1_ready, wr0_ready}, exp_g[i]); end
            n_checks++; if (mem_addr !== (exp_g[i][0] ? 13'd10 : 13'd20)) begin n_fail++; $display("FAIL rr_addr[%0d] got %0d", i, mem_addr); end
        end
        nxt();
        wr0_valid = 1'b0; wr1_valid = 1'b0;
    endtask

    task automatic test_scan_read();
        nxt();
        pos_x = 10'd3; pos_y = 10'd2; blank_n = 1'b1; clk_div2 = 1'b0;
        #1;
        n_checks++; if (in_vblank !== 1'b1) begin n_fail++; $display("FAIL pre_scan_vbl got %b exp 1", in_vblank); end
        nxt();
        clk_div2 = 1'b1; mem_rdata = 8'h5C; wr0_valid = 1'b1;
        #1;
        n_checks++; if (frame_start !== 1'b1 || in_vblank !== 1'b0) begin n_fail++; $display("FAIL frame_start got fs=%b vbl=%b exp 1 0", frame_start, in_vblank); end
        n_checks++; if (mem_addr !== 13'd185 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_slot got addr=%0d we=%b exp 185 0", mem_addr, mem_we); end
        n_checks++; if (wr0_ready !== 1'b0) begin n_fail++; $display("FAIL rd_blocks_wr got %b exp 0", wr0_ready); end
        nxt();
        clk_div2 = 1'b0;
        #1;
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_one_cycle got %b exp 0", frame_start); end
        n_checks++; if (wr0_ready !== 1'b1) begin n_fail++; $display("FAIL off_slot_wr got %b exp 1", wr0_ready); end
        nxt();
        clk_div2 = 1'b1;
        #1;
        n_checks++; if (pix_data !== 8'h5C) begin n_fail++; $display("FAIL pix_lat2 got %h exp 5c", pix_data); end
        n_checks++; if (wr0_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 13'd10) begin n_fail++; $display("FAIL hit_slot_wr got rdy=%b we=%b addr=%0d exp 1 1 10", wr0_ready, mem_we, mem_addr); end
    endtask

    task automatic test_coherency();
        nxt();
        clk_div2 = 1'b0; wr0_valid = 1'b0;
        wr1_valid = 1'b1; wr1_addr = 13'd185; wr1_data = 8'h77;
        mem_rdata = 8'h77;
        #1;
        n_checks++; if (pix_data !== 8'h5C) begin n_fail++; $display("FAIL pix_hold got %h exp 5c", pix_data); end
        n_checks++; if (wr1_ready !== 1'b1 || mem_addr !== 13'd185) begin n_fail++; $display("FAIL coh_wr got rdy=%b addr=%0d exp 1 185", wr1_ready, mem_addr); end
        nxt();
        clk_div2 = 1'b1; wr1_valid = 1'b0;
        #1;
        n_checks++; if (mem_addr !== 13'd185 || mem_we !== 1'b0) begin n_fail++; $display("FAIL coh_reread got addr=%0d we=%b exp 185 0", mem_addr, mem_we); end
        nxt();
        clk_div2 = 1'b0;
        #1;
        n_checks++; if (pix_data !== 8'h5C) begin n_fail++; $display("FAIL coh_mid got %h exp 5c", pix_data); end
        nxt();
        #1;
        n_checks++; if (pix_data !== 8'h77) begin n_fail++; $display("FAIL coh_new_pix got %h exp 77", pix_data); end
    endtask

    task automatic test_background();
        nxt();
        pos_x = 10'd95; clk_div2 = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0 || pix_data !== 8'h77) begin n_fail++; $display("FAIL bg_slot got we=%b pix=%h exp 0 77", mem_we, pix_data); end
        nxt();
        clk_div2 = 1'b0;
        #1;
        n_checks++; if (pix_data !== 8'h00) begin n_fail++; $display("FAIL bg_pix got %h exp 00", pix_data); end
    endtask

    task automatic test_vblank();
        nxt();
        pos_y = 10'd500;
        nxt();
        #1;
        n_checks++; if (vblank_start !== 1'b1 || in_vblank !== 1'b1 || frame_start !== 1'b0) begin n_fail++; $display("FAIL vbl_start got vs=%b vbl=%b fs=%b exp 1 1 0", vblank_start, in_vblank, frame_start); end
        nxt();
        #1;
        n_checks++; if (vblank_start !== 1'b0) begin n_fail++; $display("FAIL vs_one_cycle got %b exp 0", vblank_start); end
    endtask

    task automatic test_vbl_only();
        nxt();
        pos_y = 10'd2; blank_n = 1'b0; clk_div2 = 1'b0;
        wr1_valid = 1'b1; wr1_addr = 13'd42; wr1_data = 8'h9E;
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            n_checks++; if (v_wr1_ready !== 1'b0) begin n_fail++; $display("FAIL vblo_scan[%0d] got %b exp 0", i, v_wr1_ready); end
            n_checks++; if (wr1_ready !== 1'b1) begin n_fail++; $display("FAIL free_scan[%0d] got %b exp 1", i, wr1_ready); end
        end
        nxt();
        pos_y = 10'd500;
        #1;
        n_checks++; if (v_wr1_ready !== 1'b0) begin n_fail++; $display("FAIL vblo_last_scan got %b exp 0", v_wr1_ready); end
        nxt();
        #1;
        n_checks++; if (v_vblank_start !== 1'b1 || v_wr1_ready !== 1'b1) begin n_fail++; $display("FAIL vblo_grant got vs=%b rdy=%b exp 1 1", v_vblank_start, v_wr1_ready); end
        n_checks++; if (v_mem_addr !== 13'd42 || v_mem_wdata !== 8'h9E) begin n_fail++; $display("FAIL vblo_bus got addr=%0d data=%h exp 42 9e", v_mem_addr, v_mem_wdata); end
        nxt();
        wr1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_scan_read();
        test_coherency();
        test_background();
        test_vblank();
        test_vbl_only();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
